// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit path.
package serial_pkg;

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop
    } t_tx_state;

    // Even parity bit: XOR of all data bits, so total ones including parity is even.
    // Callers zero-extend narrower words; padding zeros do not change the result.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous FIFO holding words queued for transmission.
module serial_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign fill    = cnt_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_async_tx_buffered.sv
// Buffered UART-style transmitter: FIFO in front of a start/data/parity/stop framer.
module serial_async_tx_buffered
    import serial_pkg::*;
#(
    parameter int unsigned BITS          = 8,
    parameter bit          LOWBIT_FIRST  = 1'b1,
    parameter int unsigned PARITY_BITS   = 1,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned MAIN_CLK_HZ   = 80_000,
    parameter int unsigned SERIAL_CLK_HZ = 10_000,
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    input  logic [BITS-1:0]   in_parallel,
    output logic              out_accept,
    output logic              out_serial,
    output logic              out_busy,
    output logic              out_next_word,
    output logic [FILL_W-1:0] out_fill
);

    localparam int unsigned CLK_DIV  = MAIN_CLK_HZ / SERIAL_CLK_HZ;
    localparam int unsigned STOP_CYC = STOP_BITS * CLK_DIV;
    localparam int unsigned BAUD_W   = $clog2(STOP_CYC);
    localparam int unsigned BIT_W    = $clog2(BITS + 1);

    if ((MAIN_CLK_HZ % SERIAL_CLK_HZ) != 0 || CLK_DIV < 2) begin : g_bad_clk_div
        $error("MAIN_CLK_HZ/SERIAL_CLK_HZ must be an integer >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    t_tx_state         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BITS-1:0]   shift_q, shift_d, shift_nxt;
    logic              parity_q, parity_d;
    logic              serial_q, serial_d;
    logic              head_bit, bit_done, load;

    logic              fifo_pop, fifo_full, fifo_empty, fifo_push;
    logic [BITS-1:0]   fifo_rd_data;

    assign fifo_push = in_valid && out_accept;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BITS)
    ) u_fifo (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .push    (fifo_push),
        .wr_data (in_parallel),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (out_fill)
    );

    // Accept depends only on registered fill; a same-edge pop never frees a slot early.
    assign out_accept = !fifo_full;
    assign out_busy   = !fifo_empty || (state_q != Idle);
    assign out_serial = serial_q;

    // Next-state logic for the framer; the shift register's head is always the next data bit.
    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q + BAUD_W'(1);
        bit_d         = bit_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        serial_d      = serial_q;
        fifo_pop      = 1'b0;
        out_next_word = 1'b0;
        load          = 1'b0;
        bit_done      = (baud_q == BAUD_W'(CLK_DIV - 1));
        shift_nxt     = LOWBIT_FIRST ? (shift_q >> 1) : (shift_q << 1);
        head_bit      = LOWBIT_FIRST ? shift_q[0] : shift_q[BITS-1];

        unique case (state_q)
            Idle: begin
                baud_d   = '0;
                serial_d = 1'b1;
                load     = !fifo_empty;
            end
            Start: begin
                if (bit_done) begin
                    state_d  = Data;
                    baud_d   = '0;
                    bit_d    = '0;
                    serial_d = head_bit;
                end
            end
            Data: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    shift_d = shift_nxt;
                    if (bit_q == BIT_W'(BITS - 1)) begin
                        if (PARITY_BITS != 0) begin
                            state_d  = Parity;
                            serial_d = parity_q;
                        end else begin
                            state_d  = Stop;
                            serial_d = 1'b1;
                        end
                    end else begin
                        serial_d = LOWBIT_FIRST ? shift_nxt[0] : shift_nxt[BITS-1];
                    end
                end
            end
            Parity: begin
                if (bit_done) begin
                    state_d  = Stop;
                    baud_d   = '0;
                    serial_d = 1'b1;
                end
            end
            Stop: begin
                if (baud_q == BAUD_W'(STOP_CYC - 1)) begin
                    out_next_word = 1'b1;
                    baud_d        = '0;
                    if (fifo_empty) begin
                        state_d = Idle;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = Idle;
                baud_d   = '0;
                serial_d = 1'b1;
            end
        endcase

        // Frame start: pop the head and drive the start bit from the same edge.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            parity_d = even_parity(64'(fifo_rd_data));
            serial_d = 1'b0;
            state_d  = Start;
            baud_d   = '0;
        end
    end

    // Framer state; reset drops any partial frame and forces the line high at once.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= Idle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
        end
    end

endmodule

// File: tb/tb_serial_async_tx_buffered.sv
// Self-checking bench: scoreboard of pushed words against a serial-line decoder.
module tb_serial_async_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_parallel = '0;
    logic       out_accept, out_serial, out_busy, out_next_word;
    logic [2:0] out_fill;

    // Second instance: MSB first, two stop bits.
    logic       v2 = 1'b0;
    logic [7:0] p2 = '0;
    logic       acc2, ser2, busy2, nw2;
    logic [2:0] fill2;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int nw_cnt = 0;
    bit mon_en = 1'b0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    serial_async_tx_buffered dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_valid      (in_valid),
        .in_parallel   (in_parallel),
        .out_accept    (out_accept),
        .out_serial    (out_serial),
        .out_busy      (out_busy),
        .out_next_word (out_next_word),
        .out_fill      (out_fill)
    );

    serial_async_tx_buffered #(
        .LOWBIT_FIRST (1'b0),
        .STOP_BITS    (2)
    ) dut2 (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_valid      (v2),
        .in_parallel   (p2),
        .out_accept    (acc2),
        .out_serial    (ser2),
        .out_busy      (busy2),
        .out_next_word (nw2),
        .out_fill      (fill2)
    );

    always @(posedge clk) begin
        if (rst_n && out_next_word) nw_cnt <= nw_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the edge that took the word.
    task automatic send_word(input logic [7:0] w, input bit track, output int stalls);
        stalls = 0;
        in_valid = 1'b1;
        in_parallel = w;
        while (!out_accept && stalls < 2000) begin
            @(negedge clk);
            stalls++;
        end
        if (!out_accept) begin
            check_eq("accept_timeout", 32'(out_accept), 32'd1);
        end else if (track) begin
            sb_q.push_back(w);
            n_pushed++;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((out_busy || sb_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(n < 20000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Entered half a cycle after a start bit begins; samples every bit mid-period.
    task automatic rx_frames();
        bit contig;
        logic [7:0] rx, exp;
        logic par;
        do begin
            repeat (4) @(negedge clk);
            check_eq("start_bit", 32'(out_serial), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (8) @(negedge clk);
                rx[i] = out_serial;
            end
            repeat (8) @(negedge clk);
            par = out_serial;
            repeat (8) @(negedge clk);
            check_eq("stop_bit", 32'(out_serial), 32'd1);
            repeat (3) @(negedge clk);
            check_eq("next_word", 32'(out_next_word), 32'd1);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_frame", 32'(sb_q.size()), 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check_eq("data", 32'(rx), 32'(exp));
                check_eq("parity", 32'(par), 32'(^exp));
            end
            contig = (sb_q.size() != 0);
            @(negedge clk);
            if (contig) check_eq("no_gap", 32'(out_serial), 32'd0);
        end while (contig);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && out_serial === 1'b0) rx_frames();
        end
    end

    initial begin
        int st;
        logic [7:0] exp2;
        int nw_before;

        repeat (3) @(negedge clk);
        check_eq("rst_serial", 32'(out_serial), 32'd1);
        check_eq("rst_accept", 32'(out_accept), 32'd1);
        check_eq("rst_busy", 32'(out_busy), 32'd0);
        check_eq("rst_next_word", 32'(out_next_word), 32'd0);
        check_eq("rst_fill", 32'(out_fill), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single word with latency checks.
        send_word(8'hA5, 1'b1, st);
        in_valid = 1'b0;
        check_eq("lat_line_idle", 32'(out_serial), 32'd1);
        check_eq("lat_fill_1", 32'(out_fill), 32'd1);
        check_eq("lat_busy", 32'(out_busy), 32'd1);
        @(negedge clk);
        check_eq("lat_start", 32'(out_serial), 32'd0);
        check_eq("lat_fill_0", 32'(out_fill), 32'd0);
        wait_idle();
        check_eq("busy_drop", 32'(out_busy), 32'd0);

        // Parity 0 then 1, back to back.
        send_word(8'hFF, 1'b1, st);
        send_word(8'h01, 1'b1, st);
        in_valid = 1'b0;
        wait_idle();

        // Six consecutive pushes: fill reaches depth, sixth word held.
        send_word(8'h11, 1'b1, st);
        send_word(8'h22, 1'b1, st);
        check_eq("push_pop_fill", 32'(out_fill), 32'd1);
        send_word(8'h33, 1'b1, st);
        send_word(8'h44, 1'b1, st);
        send_word(8'h55, 1'b1, st);
        check_eq("full_accept", 32'(out_accept), 32'd0);
        check_eq("full_fill", 32'(out_fill), 32'd4);
        send_word(8'h66, 1'b1, st);
        check_eq("held_word_stalled", 32'(st > 0), 32'd1);
        in_valid = 1'b0;
        wait_idle();

        // Random burst at maximum rate.
        for (int i = 0; i < 20; i++) begin
            send_word(8'($urandom_range(0, 255)), 1'b1, st);
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset mid data bit, then a clean frame.
        mon_en = 1'b0;
        send_word(8'h3C, 1'b0, st);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        nw_before = nw_cnt;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_serial", 32'(out_serial), 32'd1);
        check_eq("midrst_fill", 32'(out_fill), 32'd0);
        check_eq("midrst_busy", 32'(out_busy), 32'd0);
        check_eq("midrst_accept", 32'(out_accept), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_no_next_word", 32'(nw_cnt), 32'(nw_before));
        @(negedge clk);
        mon_en = 1'b1;
        send_word(8'h5A, 1'b1, st);
        in_valid = 1'b0;
        wait_idle();
        check_eq("next_word_count", 32'(nw_cnt), 32'(n_pushed));

        // MSB first, two stop bits: push 0x80.
        v2 = 1'b1;
        p2 = 8'h80;
        @(negedge clk);
        v2 = 1'b0;
        @(negedge clk);
        check_eq("msb_start", 32'(ser2), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("msb_start_mid", 32'(ser2), 32'd0);
        exp2 = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            repeat (8) @(negedge clk);
            check_eq("msb_data", 32'(ser2), 32'(exp2[i]));
        end
        repeat (8) @(negedge clk);
        check_eq("msb_parity", 32'(ser2), 32'd1);
        repeat (4) @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            check_eq("msb_stop", 32'(ser2), 32'd1);
            check_eq("msb_next_word", 32'(nw2), 32'(j == 15));
            @(negedge clk);
        end
        check_eq("msb_idle", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
